// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared frame-store constants, shade type and RGB565 palette
package fb_pkg;

  localparam int FB_WORDS          = 2880;
  localparam int FB_WORDS_PER_LINE = 20;

  typedef logic [1:0] shadeT;

  localparam logic [15:0] PALETTE_SHADE0 = 16'hFFFF;
  localparam logic [15:0] PALETTE_SHADE1 = 16'hAD55;
  localparam logic [15:0] PALETTE_SHADE2 = 16'h52AA;
  localparam logic [15:0] PALETTE_SHADE3 = 16'h0000;

  function automatic logic [15:0] shadeToRgb(shadeT shade);
    case (shade)
      2'd0:    return PALETTE_SHADE0;
      2'd1:    return PALETTE_SHADE1;
      2'd2:    return PALETTE_SHADE2;
      default: return PALETTE_SHADE3;
    endcase
  endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// rtl/fb_scanout_if.sv - GPU framebuffer write bus and video output bundle
interface fb_scanout_if;

  logic        iFrameBufferWe;
  logic [15:0] iFrameBufferAddr;
  logic [15:0] iFrameBufferData;
  logic        iPixelEnable;
  logic [15:0] oPixel;
  logic        oHSync;
  logic        oVSync;
  logic        oDataEnable;
  logic        oFrameStart;
  logic        oWriteError;

  modport master (
    output iFrameBufferWe, iFrameBufferAddr, iFrameBufferData, iPixelEnable,
    input  oPixel, oHSync, oVSync, oDataEnable, oFrameStart, oWriteError
  );

  modport slave (
    input  iFrameBufferWe, iFrameBufferAddr, iFrameBufferData, iPixelEnable,
    output oPixel, oHSync, oVSync, oDataEnable, oFrameStart, oWriteError
  );

endinterface

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - 2880x16 simple dual-port frame store, read-first, 1-cycle read
module fb_ram
  import fb_pkg::*;
(
  input  logic        clock,
  input  logic        writeEnable,
  input  logic [11:0] writeAddr,
  input  logic [15:0] writeData,
  input  logic        readEnable,
  input  logic [11:0] readAddr,
  output logic [15:0] readData
);

  logic [15:0] mem [FB_WORDS];

  // Both ports in one block so a same-address collision returns the old word.
  always_ff @(posedge clock) begin
    if (writeEnable) mem[writeAddr] <= writeData;
    if (readEnable)  readData <= mem[readAddr];
  end

endmodule

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - captures GPU framebuffer writes and rasterises them as RGB565
module fb_scanout
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = 160,
  parameter int H_FRONT  = 8,
  parameter int H_SYNC   = 16,
  parameter int H_BACK   = 24,
  parameter int V_ACTIVE = 144,
  parameter int V_FRONT  = 3,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 4
) (
  input  logic        iClock,
  input  logic        iReset_n,
  fb_scanout_if.slave bus
);

  localparam logic [7:0] H_VIS      = 8'(H_ACTIVE);
  localparam logic [7:0] H_SYNC_ON  = 8'(H_ACTIVE + H_FRONT);
  localparam logic [7:0] H_SYNC_OFF = 8'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [7:0] H_LAST     = 8'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [7:0] V_VIS      = 8'(V_ACTIVE);
  localparam logic [7:0] V_SYNC_ON  = 8'(V_ACTIVE + V_FRONT);
  localparam logic [7:0] V_SYNC_OFF = 8'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [7:0] V_LAST     = 8'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [7:0]  hCnt, vCnt;
  logic        inRange, writeError;
  logic        active, hSync0, vSync0, frameStart0;
  logic [11:0] readAddr;
  logic [15:0] ramData, shifted;
  logic        s1Active, s1HSync, s1VSync, s1FrameStart;
  logic [2:0]  s1Sub;
  logic [15:0] pixelQ;
  logic        hSyncQ, vSyncQ, dataEnableQ, frameStartQ;

  assign inRange = bus.iFrameBufferAddr < 16'(FB_WORDS);

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n)                             writeError <= 1'b0;
    else if (bus.iFrameBufferWe && !inRange)   writeError <= 1'b1;
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      hCnt <= 8'd0;
      vCnt <= 8'd0;
    end else if (bus.iPixelEnable) begin
      if (hCnt == H_LAST) begin
        hCnt <= 8'd0;
        vCnt <= (vCnt == V_LAST) ? 8'd0 : vCnt + 8'd1;
      end else begin
        hCnt <= hCnt + 8'd1;
      end
    end
  end

  assign active      = (hCnt < H_VIS) && (vCnt < V_VIS);
  assign hSync0      = (hCnt >= H_SYNC_ON) && (hCnt < H_SYNC_OFF);
  assign vSync0      = (vCnt >= V_SYNC_ON) && (vCnt < V_SYNC_OFF);
  assign frameStart0 = (hCnt == 8'd0) && (vCnt == 8'd0);
  // vCnt*20 without a multiplier: 16*v + 4*v + word-within-line.
  assign readAddr    = {vCnt, 4'b0000} + {2'b00, vCnt, 2'b00} + {7'd0, hCnt[7:3]};

  fb_ram ram (
    .clock       (iClock),
    .writeEnable (bus.iFrameBufferWe && inRange),
    .writeAddr   (bus.iFrameBufferAddr[11:0]),
    .writeData   (bus.iFrameBufferData),
    .readEnable  (bus.iPixelEnable && active),
    .readAddr    (readAddr),
    .readData    (ramData)
  );

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      s1Active     <= 1'b0;
      s1HSync      <= 1'b0;
      s1VSync      <= 1'b0;
      s1FrameStart <= 1'b0;
      s1Sub        <= 3'd0;
    end else if (bus.iPixelEnable) begin
      s1Active     <= active;
      s1HSync      <= hSync0;
      s1VSync      <= vSync0;
      s1FrameStart <= frameStart0;
      s1Sub        <= hCnt[2:0];
    end
  end

  // Pixel 0 of a word sits in the top two bits; shift the wanted pixel up there.
  assign shifted = ramData << {s1Sub, 1'b0};

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      pixelQ      <= 16'h0000;
      hSyncQ      <= 1'b0;
      vSyncQ      <= 1'b0;
      dataEnableQ <= 1'b0;
      frameStartQ <= 1'b0;
    end else if (bus.iPixelEnable) begin
      pixelQ      <= s1Active ? shadeToRgb(shifted[15:14]) : 16'h0000;
      hSyncQ      <= s1HSync;
      vSyncQ      <= s1VSync;
      dataEnableQ <= s1Active;
      frameStartQ <= s1FrameStart;
    end
  end

  assign bus.oPixel      = pixelQ;
  assign bus.oHSync      = hSyncQ;
  assign bus.oVSync      = vSyncQ;
  assign bus.oDataEnable = dataEnableQ;
  assign bus.oFrameStart = frameStartQ;
  assign bus.oWriteError = writeError;

endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - self-checking bench for fb_scanout
module tb_fb_scanout;

  localparam int HT    = 208;
  localparam int VT    = 154;
  localparam int FRAME = HT * VT;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  initial forever #5 clk = ~clk;

  fb_scanout_if fbIf ();
  fb_scanout dut (.iClock(clk), .iReset_n(rstN), .bus(fbIf.slave));

  typedef struct packed {
    logic [15:0] pix;
    logic        hs, vs, de, fs, err;
  } outT;

  typedef struct {
    int               addr;
    logic [15:0]      data;
    int               y;
    int               x0;
    logic [0:7][15:0] px;
  } vecT;

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] mem [2880];
  logic [15:0] cap [144][160];
  outT  pend   = '0;
  outT  expOut = '0;
  logic errExp = 1'b0;
  int   pos    = 0;
  bit   chkOn  = 0;
  int   enMode = 0;
  int   enPhase = 0;

  int cyc = 0, capX = 0, capY = 999, fsCount = 0;
  int lastDeRise, lastDeFall, lastHsRise, lastVsRise, lastFs;
  int deLen, hsLen, hsGap, hsPeriod, vsLen, fsPeriod;
  logic pDe = 0, pHs = 0, pVs = 0;

  vecT vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clearMeas();
    lastDeRise = -1; lastDeFall = -1; lastHsRise = -1; lastVsRise = -1; lastFs = -1;
    deLen = -1; hsLen = -1; hsGap = -1; hsPeriod = -1; vsLen = -1; fsPeriod = -1;
    fsCount = 0;
  endtask

  function automatic logic [15:0] pal(int s);
    case (s)
      0:       return 16'hFFFF;
      1:       return 16'hAD55;
      2:       return 16'h52AA;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected video for frame position p (raster order), from the display rules.
  function automatic outT modelAt(int p);
    int x = p % HT;
    int y = p / HT;
    outT o = '0;
    if (x < 160 && y < 144) begin
      int w = int'(mem[y * 20 + x / 8]);
      o.pix = pal((w >> (14 - 2 * (x % 8))) & 3);
      o.de  = 1'b1;
    end
    o.hs = (x >= 168 && x < 184);
    o.vs = (y >= 147 && y < 150);
    o.fs = (p == 0);
    return o;
  endfunction

  function automatic outT outsNow();
    return {fbIf.oPixel, fbIf.oHSync, fbIf.oVSync, fbIf.oDataEnable, fbIf.oFrameStart,
            fbIf.oWriteError};
  endfunction

  // Reference model: two enable-steps of delay between a position and its output.
  initial forever begin
    @(posedge clk or negedge rstN);
    if (!rstN) begin
      pos = 0; pend = '0; expOut = '0; errExp = 1'b0;
    end else begin
      if (fbIf.iPixelEnable) begin
        expOut = pend;
        pend   = modelAt(pos);
        pos    = (pos + 1) % FRAME;
      end
      if (fbIf.iFrameBufferWe) begin
        if (int'(fbIf.iFrameBufferAddr) < 2880) mem[int'(fbIf.iFrameBufferAddr)] = fbIf.iFrameBufferData;
        else errExp = 1'b1;
      end
    end
  end

  initial forever begin
    outT e;
    @(negedge clk);
    if (chkOn) begin
      e = expOut;
      e.err = errExp;
      chk("scanout", 64'(outsNow()), 64'(e));
    end
  end

  initial forever begin
    @(negedge clk);
    #1;
    enPhase++;
    case (enMode)
      0:       fbIf.iPixelEnable = 1'b0;
      1:       fbIf.iPixelEnable = 1'b1;
      default: fbIf.iPixelEnable = (enPhase % 3 == 0);
    endcase
  end

  // Output-side measurement and frame capture, derived only from the video outputs.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (fbIf.oDataEnable && !pDe) lastDeRise = cyc;
    if (!fbIf.oDataEnable && pDe) begin
      if (lastDeRise >= 0) deLen = cyc - lastDeRise;
      lastDeFall = cyc;
    end
    if (fbIf.oHSync && !pHs) begin
      if (lastHsRise >= 0) hsPeriod = cyc - lastHsRise;
      if (lastDeFall >= 0 && cyc - lastDeFall < HT) hsGap = cyc - lastDeFall;
      lastHsRise = cyc;
    end
    if (!fbIf.oHSync && pHs && lastHsRise >= 0) hsLen = cyc - lastHsRise;
    if (fbIf.oVSync && !pVs) lastVsRise = cyc;
    if (!fbIf.oVSync && pVs && lastVsRise >= 0) vsLen = cyc - lastVsRise;
    if (enMode == 1) begin
      if (fbIf.oFrameStart) begin
        if (lastFs >= 0) fsPeriod = cyc - lastFs;
        lastFs = cyc; fsCount++; capX = 0; capY = 0;
      end
      if (fbIf.oDataEnable) begin
        if (capY < 144 && capX < 160) cap[capY][capX] = fbIf.oPixel;
        capX++;
      end else if (pDe) begin
        capY++; capX = 0;
      end
    end
    pDe = fbIf.oDataEnable; pHs = fbIf.oHSync; pVs = fbIf.oVSync;
  end

  initial begin
    int  nEn;
    bit  seen;
    vecs[0] = '{0,    16'h1B1B, 0,   0,   {16'hFFFF, 16'hAD55, 16'h52AA, 16'h0000, 16'hFFFF, 16'hAD55, 16'h52AA, 16'h0000}};
    vecs[1] = '{21,   16'hFFFF, 1,   8,   {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[2] = '{20,   16'hE4E4, 1,   0,   {16'h0000, 16'h52AA, 16'hAD55, 16'hFFFF, 16'h0000, 16'h52AA, 16'hAD55, 16'hFFFF}};
    vecs[3] = '{1,    16'h0000, 0,   8,   {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
    vecs[4] = '{2879, 16'h5555, 143, 152, {16'hAD55, 16'hAD55, 16'hAD55, 16'hAD55, 16'hAD55, 16'hAD55, 16'hAD55, 16'hAD55}};
    vecs[5] = '{2860, 16'hAAAA, 143, 0,   {16'h52AA, 16'h52AA, 16'h52AA, 16'h52AA, 16'h52AA, 16'h52AA, 16'h52AA, 16'h52AA}};
    vecs[6] = '{159,  16'h3C96, 7,   152, {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h52AA, 16'hAD55, 16'hAD55, 16'h52AA}};

    fbIf.iFrameBufferWe = 1'b0; fbIf.iFrameBufferAddr = '0; fbIf.iFrameBufferData = '0;
    fbIf.iPixelEnable = 1'b0;
    clearMeas();
    enMode = 1;
    repeat (4) step();
    chk("reset_outputs", 64'(outsNow()), 64'(0));

    enMode = 0; chkOn = 1;
    step(); rstN = 1'b1;
    for (int a = 0; a < 2880; a++) begin
      step();
      fbIf.iFrameBufferWe = 1'b1; fbIf.iFrameBufferAddr = 16'(a); fbIf.iFrameBufferData = 16'($urandom);
    end
    foreach (vecs[i]) begin
      step();
      fbIf.iFrameBufferAddr = 16'(vecs[i].addr); fbIf.iFrameBufferData = vecs[i].data;
    end
    step(); fbIf.iFrameBufferAddr = 16'd2880; fbIf.iFrameBufferData = 16'h0000;
    step(); fbIf.iFrameBufferAddr = 16'hFFFF; fbIf.iFrameBufferData = 16'h1234;
    step(); fbIf.iFrameBufferWe = 1'b0;
    chk("write_error_set", 64'(fbIf.oWriteError), 64'(1));
    repeat (3) step();
    chk("write_error_sticky", 64'(fbIf.oWriteError), 64'(1));

    // Reset held with enable high, then first frame start two clocks after release.
    rstN = 1'b0; enMode = 1;
    repeat (3) step();
    chk("reset_hold_outputs", 64'(outsNow()), 64'(0));
    step(); clearMeas(); rstN = 1'b1;
    @(negedge clk);
    chk("fs_de_after_1clk", 64'({fbIf.oFrameStart, fbIf.oDataEnable}), 64'(0));
    @(negedge clk);
    chk("fs_de_after_2clk", 64'({fbIf.oFrameStart, fbIf.oDataEnable}), 64'(3));
    chk("pixel_0_0", 64'(fbIf.oPixel), 64'(16'hFFFF));

    for (int i = 0; i < 40000 && capY != 144; i++) step();
    chk("frame_captured", 64'(capY), 64'(144));
    foreach (vecs[i])
      for (int k = 0; k < 8; k++)
        chk($sformatf("vec%0d_px%0d", i, k), 64'(cap[vecs[i].y][vecs[i].x0 + k]), 64'(vecs[i].px[k]));

    for (int i = 0; i < 45000 && !(fsCount >= 2 && capY >= 50); i++) step();
    chk("reached_line50", 64'(fsCount >= 2 && capY >= 50), 64'(1));
    chk("de_len", 64'(deLen), 64'(160));
    chk("hs_len", 64'(hsLen), 64'(16));
    chk("hs_gap", 64'(hsGap), 64'(8));
    chk("line_period", 64'(hsPeriod), 64'(208));
    chk("vs_len", 64'(vsLen), 64'(3 * 208));
    chk("frame_period", 64'(fsPeriod), 64'(FRAME));

    // Mid-frame reset pulse, then enable every third clock.
    step(); rstN = 1'b0; #1;
    chk("midframe_reset_outputs", 64'(outsNow()), 64'(0));
    enMode = 3;
    repeat (4) step();
    clearMeas(); rstN = 1'b1;
    nEn = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); if (fbIf.iPixelEnable) nEn++;
      @(negedge clk); if (fbIf.oFrameStart) seen = 1;
    end
    chk("fs_seen_after_reset", 64'(seen), 64'(1));
    chk("fs_enables_after_reset", 64'(nEn), 64'(2));

    for (int i = 0; i < 2200; i++) begin
      step();
      fbIf.iFrameBufferWe   = ($urandom_range(0, 2) == 0);
      fbIf.iFrameBufferAddr = ($urandom_range(0, 199) == 0) ? 16'(2880 + $urandom_range(0, 500))
                                                            : 16'($urandom_range(0, 79));
      fbIf.iFrameBufferData = 16'($urandom);
    end
    step(); fbIf.iFrameBufferWe = 1'b0;
    chk("line_period_div3", 64'(hsPeriod), 64'(624));
    chk("hs_len_div3", 64'(hsLen), 64'(48));
    chk("de_len_div3", 64'(deLen), 64'(480));

    step();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display scanout stage directly downstream of the GPU. Captures the GPU's framebuffer write stream (we/addr/data, 8 packed 2-bit pixels per word) into an internal 160x144 frame store. Independently rasterises the store at a programmable display timing, emitting RGB565 pixels with hsync/vsync/data-enable to the LCD/video DAC. Writes and scanout run concurrently on one clock; tearing is permitted.

## Interface
Parameters:
- H_ACTIVE, 160, visible pixels per line
- H_FRONT, 8, front-porch pixels
- H_SYNC, 16, hsync width in pixels
- H_BACK, 24, back-porch pixels (H_TOTAL = 208)
- V_ACTIVE, 144, visible lines
- V_FRONT, 3 / V_SYNC, 3 / V_BACK, 4, vertical porch/sync lines (V_TOTAL = 154)

Ports:
- iClock  in  1  system clock
- iReset_n  in  1  asynchronous, active-low reset
- iFrameBufferWe  in  1  write strobe from GPU
- iFrameBufferAddr  in  16  word address; valid 0..2879 (20 words/line)
- iFrameBufferData  in  16  8 pixels; pixel k at bits [15-2k:14-2k]
- iPixelEnable  in  1  pixel-rate clock enable
- oPixel  out  16  RGB565 pixel
- oHSync, oVSync  out  1  active-high syncs
- oDataEnable  out  1  active-area pixel valid
- oFrameStart  out  1  high with pixel (0,0)
- oWriteError  out  1  sticky: out-of-range write seen

## Operation
- Write port: on iFrameBufferWe with addr < 2880, store data at addr on that clock edge. Independent of iPixelEnable. Addr >= 2880: write dropped, oWriteError set to 1; cleared only by reset.
- Counters hcnt (0..H_TOTAL-1), vcnt (0..V_TOTAL-1) advance only on iPixelEnable cycles. hcnt wraps to 0 and increments vcnt. vcnt wraps 0 after V_TOTAL-1.
- Stage 0 (counter state): active = hcnt<H_ACTIVE && vcnt<V_ACTIVE. Read address = vcnt*20 + hcnt[7:3], computed as (vcnt<<4)+(vcnt<<2)+hcnt[7:3], 12 bits. Read only when active.
- Stage 1: RAM read data valid. hcnt[2:0] is delayed alongside and selects a 2-bit shade.
- Stage 2: palette map to output registers. Shade 0 maps to FFFF, 1 to AD55, 2 to 52AA, 3 to 0000.
- Outside the active area, oPixel = 0000 and oDataEnable = 0.
- hsync = hcnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC). vsync uses the same rule on vcnt with V_*.
- frame start = (hcnt==0 && vcnt==0).
- Syncs, data-enable and frame start are delayed through the same two stages as pixel data.
- Same-address write and read in one cycle: read returns old data (read-first).

## Timing
- Reset values: oPixel=0, oHSync=0, oVSync=0, oDataEnable=0, oFrameStart=0, oWriteError=0, hcnt=vcnt=0, pipeline valid bits 0. Frame store contents are not reset.
- Reset assertion mid-frame: counters and outputs return to reset values immediately (async). Scanout restarts at (0,0) on the first iPixelEnable after deassertion.
- Latency: the output for counter position (x,y) appears on the 2nd iPixelEnable edge after the counters hold (x,y). The first valid oDataEnable follows the 2nd enable after reset release.
- Outputs change only on iPixelEnable cycles and hold otherwise. iPixelEnable tied high gives one pixel per clock.
- A write is visible to any scanout read issued on a later clock.

## Structure
- Shared package fb_pkg:
  - FB_WORDS=2880 and FB_WORDS_PER_LINE=20
  - 2-bit shade type
  - the four RGB565 palette constants
- Sub-module fb_ram: 2880x16 simple dual-port RAM, one write and one synchronous read port, read-first, 1-cycle read latency. Inferable as block RAM.
- Top: write decode/error flag, counters, 3-stage pipeline, sync generation.

## Test plan
- Reset: hold iReset_n low, iPixelEnable=1 → all outputs 0. After release, first oFrameStart=1 occurs 2 clocks later with oDataEnable=1.
- Pixel decode: write addr 0 = 1B1B, iPixelEnable=1 → line 0, x0..7 oPixel = FFFF, AD55, 52AA, 0000, FFFF, AD55, 52AA, 0000.
- Address mapping: write addr 21 = FFFF → line 1, x8..15 = 0000 (×8). Line 1 x0..7 and line 0 x8..15 are unaffected by this write.
- Out-of-range: write addr 2880 = 0000 → oWriteError=1 and stays 1. No stored word changes; readback of words 0 and 2879 is unchanged.
- Sync timing: oDataEnable high 160 clocks per line. oHSync high exactly 16 clocks, starting 8 clocks after oDataEnable falls. Line period 208 clocks; oVSync high 3 lines; frame period 154×208 clocks.
- Enable gating and reset mid-frame:
  - iPixelEnable every 3rd clock → outputs hold between enables and the line period is 624 clocks.
  - Pulse iReset_n low at line 50 → outputs go 0 at once; the next oFrameStart follows 2 enables after release.
